// File: rtl/maxpool2x2_ram_ctrl_pkg.sv
// Shared types and defaults for the 2x2/stride-2 max-pool RAM sequencer.
package maxpool2x2_ram_ctrl_pkg;

   localparam int AW_DEF    = 32;
   localparam int DIM_W_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD0,
      S_RD1,
      S_RD2,
      S_RD3,
      S_WR,
      S_FIN
   } state_t;

endpackage

// File: rtl/maxpool2x2_ram_ctrl_if.sv
// Layer-controller handshake plus feature-map RAM port of the max-pool sequencer.
interface maxpool2x2_ram_ctrl_if
   import maxpool2x2_ram_ctrl_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DIM_W = DIM_W_DEF
);
   logic             start;
   logic [AW-1:0]    in_base;
   logic [AW-1:0]    out_base;
   logic [DIM_W-1:0] map_w;
   logic [DIM_W-1:0] map_h;
   logic             busy;
   logic             done;
   logic             ram_en;
   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [7:0]       ram_wdata;
   logic [7:0]       ram_rdata;

   // master: layer controller + RAM side; slave: the sequencer
   modport master (
      output start, in_base, out_base, map_w, map_h, ram_rdata,
      input  busy, done, ram_en, ram_we, ram_addr, ram_wdata
   );
   modport slave (
      input  start, in_base, out_base, map_w, map_h, ram_rdata,
      output busy, done, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/maxpool2x2_ram_ctrl_max8.sv
// Combinational 8-bit max; ties return i_a so the accumulator is kept.
module maxpool2x2_ram_ctrl_max8 #(
   parameter bit SIGNED = 1'b1
) (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   output logic [7:0] o_y
);
   logic w_b_gt;

   assign w_b_gt = SIGNED ? ($signed(i_b) > $signed(i_a)) : (i_b > i_a);
   assign o_y    = w_b_gt ? i_b : i_a;
endmodule

// File: rtl/maxpool2x2_ram_ctrl.sv
// One 2x2/stride-2 max-pool pass over a feature map in a single-port RAM,
// 5 cycles per output pixel (4 reads, 1 write).
module maxpool2x2_ram_ctrl
   import maxpool2x2_ram_ctrl_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DIM_W  = DIM_W_DEF,
   parameter bit SIGNED = 1'b1
) (
   input logic                 clk,
   input logic                 rstn,
   maxpool2x2_ram_ctrl_if.slave bus
);
   state_t           r_state;
   logic [AW-1:0]    r_mw;
   logic [AW-1:0]    r_row;
   logic [AW-1:0]    r_win;
   logic [AW-1:0]    r_out;
   logic [AW-1:0]    r_addr;
   logic [DIM_W-1:0] r_ow, r_oh, r_i, r_j;
   logic [7:0]       r_acc;
   logic             r_busy, r_done, r_en, r_we;

   logic [DIM_W-1:0] w_ow, w_oh;
   logic [AW-1:0]    w_row_nxt;
   logic [7:0]       w_fold;
   logic             w_last_col, w_last;

   assign w_ow       = bus.map_w >> 1;
   assign w_oh       = bus.map_h >> 1;
   assign w_row_nxt  = r_row + (r_mw << 1);
   assign w_last_col = (r_j == r_ow - DIM_W'(1));
   assign w_last     = w_last_col && (r_i == r_oh - DIM_W'(1));

   // Shared by the RD2/RD3 accumulator fold and the WR-cycle fold of pixel 4
   maxpool2x2_ram_ctrl_max8 #(.SIGNED(SIGNED)) u_max (
      .i_a (r_acc),
      .i_b (bus.ram_rdata),
      .o_y (w_fold)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_mw    <= '0;
         r_row   <= '0;
         r_win   <= '0;
         r_out   <= '0;
         r_addr  <= '0;
         r_ow    <= '0;
         r_oh    <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_acc   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_en    <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.start) begin
               r_mw  <= AW'(bus.map_w);
               r_ow  <= w_ow;
               r_oh  <= w_oh;
               r_row <= bus.in_base;
               r_win <= bus.in_base;
               r_out <= bus.out_base;
               r_i   <= '0;
               r_j   <= '0;
               if (w_ow == '0 || w_oh == '0) begin
                  r_state <= S_FIN;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_RD0;
                  r_busy  <= 1'b1;
                  r_en    <= 1'b1;
                  r_we    <= 1'b0;
                  r_addr  <= bus.in_base;
               end
            end
            S_RD0: begin
               r_state <= S_RD1;
               r_addr  <= r_win + AW'(1);
            end
            S_RD1: begin
               r_state <= S_RD2;
               r_acc   <= bus.ram_rdata;
               r_addr  <= r_win + r_mw;
            end
            S_RD2: begin
               r_state <= S_RD3;
               r_acc   <= w_fold;
               r_addr  <= r_win + r_mw + AW'(1);
            end
            S_RD3: begin
               r_state <= S_WR;
               r_acc   <= w_fold;
               r_we    <= 1'b1;
               r_addr  <= r_out;
            end
            S_WR: begin
               r_we  <= 1'b0;
               r_out <= r_out + AW'(1);
               if (w_last) begin
                  r_state <= S_FIN;
                  r_busy  <= 1'b0;
                  r_en    <= 1'b0;
                  r_done  <= 1'b1;
                  r_addr  <= '0;
               end else if (w_last_col) begin
                  // next output row starts two input rows further down
                  r_state <= S_RD0;
                  r_j     <= '0;
                  r_i     <= r_i + DIM_W'(1);
                  r_row   <= w_row_nxt;
                  r_win   <= w_row_nxt;
                  r_addr  <= w_row_nxt;
               end else begin
                  r_state <= S_RD0;
                  r_j     <= r_j + DIM_W'(1);
                  r_win   <= r_win + AW'(2);
                  r_addr  <= r_win + AW'(2);
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.ram_en    = r_en;
   assign bus.ram_we    = r_we;
   assign bus.ram_addr  = r_addr;
   assign bus.ram_wdata = r_we ? w_fold : 8'h00;
endmodule

// File: tb/tb_maxpool2x2_ram_ctrl.sv
// Bench: signed and unsigned sequencers run side by side on identical RAM images,
// checked against a sequential pooling model and hand-computed corner cases.
module tb_maxpool2x2_ram_ctrl;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic        start = 1'b0;
   logic [31:0] in_base = '0, out_base = '0;
   logic [7:0]  map_w = '0, map_h = '0;

   maxpool2x2_ram_ctrl_if #(.AW(32), .DIM_W(8)) ifs ();
   maxpool2x2_ram_ctrl_if #(.AW(32), .DIM_W(8)) ifu ();

   maxpool2x2_ram_ctrl #(.AW(32), .DIM_W(8), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rstn(rstn), .bus(ifs));
   maxpool2x2_ram_ctrl #(.AW(32), .DIM_W(8), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rstn(rstn), .bus(ifu));

   logic        en[2], we[2], bsy[2], dn[2];
   logic [31:0] ad[2];
   logic [7:0]  wd[2], rd[2];
   logic [7:0]  mem[2][256];

   assign ifs.start = start;   assign ifu.start = start;
   assign ifs.in_base = in_base;   assign ifu.in_base = in_base;
   assign ifs.out_base = out_base; assign ifu.out_base = out_base;
   assign ifs.map_w = map_w;   assign ifu.map_w = map_w;
   assign ifs.map_h = map_h;   assign ifu.map_h = map_h;
   assign ifs.ram_rdata = rd[0];   assign ifu.ram_rdata = rd[1];
   assign en[0] = ifs.ram_en;  assign en[1] = ifu.ram_en;
   assign we[0] = ifs.ram_we;  assign we[1] = ifu.ram_we;
   assign bsy[0] = ifs.busy;   assign bsy[1] = ifu.busy;
   assign dn[0] = ifs.done;    assign dn[1] = ifu.done;
   assign ad[0] = ifs.ram_addr;    assign ad[1] = ifu.ram_addr;
   assign wd[0] = ifs.ram_wdata;   assign wd[1] = ifu.ram_wdata;

   // RAM models: synchronous, one-cycle registered read
   always @(posedge clk)
      for (int k = 0; k < 2; k++)
         if (en[k]) begin
            if (we[k]) mem[k][ad[k][7:0]] = wd[k];
            else        rd[k] <= mem[k][ad[k][7:0]];
         end

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [7:0]  wd;
   } acc_t;

   acc_t q[2][$];
   acc_t exq[2][$];
   int   cyc = 0, start_cyc = 0;
   int   busy_cnt[2], done_cnt[2], done_cyc[2], viol[2];
   int   nchk = 0, npass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      for (int k = 0; k < 2; k++) begin
         if (rstn && en[k]) q[k].push_back(acc_t'{we[k], ad[k], wd[k]});
         if (bsy[k]) busy_cnt[k]++;
         if (en[k] && !bsy[k]) viol[k]++;
         if (dn[k]) begin
            done_cnt[k]++;
            done_cyc[k] = cyc;
            if (bsy[k] || en[k]) viol[k]++;
         end
      end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
   endtask

   function automatic logic [43:0] outs(input int k);
      return {bsy[k], dn[k], en[k], we[k], ad[k], wd[k]};
   endfunction

   function automatic logic [7:0] pmax(input bit sgn, input logic [7:0] a, input logic [7:0] b);
      if (sgn) return ($signed(a) >= $signed(b)) ? a : b;
      return (a >= b) ? a : b;
   endfunction

   // Reference: pool window by window on a private copy of the RAM, so in-place
   // passes see the same overwritten data the hardware would
   task automatic build_exp(input int k, input int mw, input int mh, input int ib, input int ob);
      logic [7:0]  m[256];
      logic [31:0] a[4];
      logic [31:0] wa;
      logic [7:0]  best;
      for (int x = 0; x < 256; x++) m[x] = mem[k][x];
      exq[k].delete();
      for (int i = 0; i < mh / 2; i++)
         for (int j = 0; j < mw / 2; j++) begin
            a[0] = 32'(ib + 2 * i * mw + 2 * j);
            a[1] = a[0] + 32'd1;
            a[2] = a[0] + 32'(mw);
            a[3] = a[2] + 32'd1;
            best = m[a[0][7:0]];
            for (int p = 0; p < 4; p++) begin
               exq[k].push_back(acc_t'{1'b0, a[p], 8'h00});
               best = pmax(k == 0, best, m[a[p][7:0]]);
            end
            wa = 32'(ob + i * (mw / 2) + j);
            exq[k].push_back(acc_t'{1'b1, wa, best});
            m[wa[7:0]] = best;
         end
   endtask

   task automatic run_pass(input int mw, input int mh, input int ib, input int ob,
                           input int exp_busy, input bit glitch, input string tag);
      int t, bad, nwr;
      for (int k = 0; k < 2; k++) begin
         build_exp(k, mw, mh, ib, ob);
         q[k].delete();
         busy_cnt[k] = 0; done_cnt[k] = 0; viol[k] = 0;
      end
      map_w = 8'(mw); map_h = 8'(mh); in_base = 32'(ib); out_base = 32'(ob);
      start = 1'b1;
      start_cyc = cyc;
      step();
      start = 1'b0;
      if (glitch) begin
         map_w = 8'd2; map_h = 8'd6; in_base = 32'd77; out_base = 32'd3;
      end
      t = 0;
      while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && t < 1000) begin
         start = glitch && (t == 3);
         step();
         t++;
      end
      start = 1'b0;
      chk({tag, "_timeout"}, t < 1000, 1);
      step(); step();
      for (int k = 0; k < 2; k++) begin
         bad = -1; nwr = 0;
         chk($sformatf("%s_len%0d", tag, k), q[k].size(), exq[k].size());
         for (int x = 0; x < q[k].size() && x < exq[k].size(); x++) begin
            if (q[k][x].we) nwr++;
            if (bad < 0 && (q[k][x].we != exq[k][x].we || q[k][x].addr != exq[k][x].addr ||
                            (exq[k][x].we && q[k][x].wd != exq[k][x].wd))) bad = x;
         end
         chk($sformatf("%s_seq%0d_firstbad", tag, k), bad, -1);
         chk($sformatf("%s_nwr%0d", tag, k), nwr, exp_busy / 5);
         chk($sformatf("%s_busy%0d", tag, k), busy_cnt[k], exp_busy);
         chk($sformatf("%s_done%0d", tag, k), done_cnt[k], 1);
         chk($sformatf("%s_donelat%0d", tag, k), done_cyc[k] - start_cyc, exp_busy + 1);
         chk($sformatf("%s_viol%0d", tag, k), viol[k], 0);
      end
   endtask

   task automatic fill_rand();
      logic [7:0] v;
      for (int x = 0; x < 256; x++) begin
         v = 8'($urandom);
         mem[0][x] = v; mem[1][x] = v;
      end
   endtask

   typedef struct {
      int mw, mh, ib, ob, busy;
   } vec_t;
   vec_t tbl[8];

   initial begin
      int t;
      tbl[0] = '{4, 4, 0, 100, 20};
      tbl[1] = '{5, 3, 0, 100, 10};
      tbl[2] = '{1, 4, 0, 100, 0};
      tbl[3] = '{4, 1, 0, 100, 0};
      tbl[4] = '{6, 4, 10, 0, 30};
      tbl[5] = '{7, 5, 20, 20, 30};
      tbl[6] = '{2, 2, 50, 200, 5};
      tbl[7] = '{8, 6, 30, 130, 60};

      fill_rand();
      repeat (3) step();
      for (int k = 0; k < 2; k++) chk($sformatf("reset_outs%0d", k), outs(k), 0);
      rstn = 1'b1;
      step();
      for (int k = 0; k < 2; k++) chk($sformatf("idle_outs%0d", k), outs(k), 0);

      // 4x4 ramp: known pooled values
      for (int x = 0; x < 16; x++) begin mem[0][x] = 8'(x); mem[1][x] = 8'(x); end
      run_pass(4, 4, 0, 100, 20, 1'b0, "ramp");
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("ramp_w100_%0d", k), mem[k][100], 5);
         chk($sformatf("ramp_w101_%0d", k), mem[k][101], 7);
         chk($sformatf("ramp_w102_%0d", k), mem[k][102], 13);
         chk($sformatf("ramp_w103_%0d", k), mem[k][103], 15);
      end

      // signedness of the compare
      mem[0][0] = 8'h80; mem[0][1] = 8'hFF; mem[0][2] = 8'hFB; mem[0][3] = 8'h80;
      for (int x = 0; x < 4; x++) mem[1][x] = mem[0][x];
      run_pass(2, 2, 0, 150, 5, 1'b0, "sgnA");
      chk("sgnA_signed", mem[0][150], 8'hFF);
      chk("sgnA_unsigned", mem[1][150], 8'hFF);
      mem[0][0] = 8'h80; mem[0][1] = 8'h01; mem[0][2] = 8'h7F; mem[0][3] = 8'h02;
      for (int x = 0; x < 4; x++) mem[1][x] = mem[0][x];
      run_pass(2, 2, 0, 150, 5, 1'b0, "sgnB");
      chk("sgnB_signed", mem[0][150], 8'h7F);
      chk("sgnB_unsigned", mem[1][150], 8'h80);

      for (int v = 0; v < 8; v++) begin
         fill_rand();
         run_pass(tbl[v].mw, tbl[v].mh, tbl[v].ib, tbl[v].ob, tbl[v].busy, 1'b0,
                  $sformatf("vec%0d", v));
      end

      // restart and config changes during a pass are ignored
      fill_rand();
      run_pass(4, 4, 0, 100, 20, 1'b1, "glitch");

      // reset during RD2 of the second window
      fill_rand();
      for (int k = 0; k < 2; k++) begin q[k].delete(); done_cnt[k] = 0; end
      map_w = 8'd4; map_h = 8'd4; in_base = 32'd0; out_base = 32'd100;
      start = 1'b1;
      step();
      start = 1'b0;
      t = 0;
      while (q[0].size() < 8 && t < 100) begin step(); t++; end
      chk("rst_reach", q[0].size(), 8);
      rstn = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) chk($sformatf("rst_outs%0d", k), outs(k), 0);
      step(); step();
      rstn = 1'b1;
      repeat (25) step();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_nodone%0d", k), done_cnt[k], 0);
         chk($sformatf("rst_idle%0d", k), outs(k), 0);
      end
      fill_rand();
      run_pass(4, 4, 0, 100, 20, 1'b0, "postrst");

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
